// File: rtl/spi_pkg.sv
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared types and constants for the oversampling SPI responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    END    = 2'd2
  } spi_os_state_t;

  localparam int SPI_SYNC_STAGES    = 2;
  localparam int SPI_MIN_OVERSAMPLE = 4;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// Module   : spi_sync_edge
// Brief    : Multi-flop synchroniser with one extra stage for rise/fall detect.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int STAGES = SPI_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-1:0], d_i};
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o =  sync_q[STAGES-1] & ~sync_q[STAGES];
  assign fall_o = ~sync_q[STAGES-1] &  sync_q[STAGES];

endmodule

`default_nettype wire

// File: rtl/spi_slave_os.sv
// ============================================================================
// Module   : spi_slave_os
// Brief    : clk-oversampled SPI responder (CPOL=0, MSB first) with
//            valid/ready receive/transmit handshakes. Optional macro
//            SPI_SLAVE_OS_ERR_EN enables the err pulse output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_slave_os
  import spi_pkg::*;
#(
  parameter int WIDTH   = 13,
  parameter int CLKFREQ = 27000000,
  parameter int SPIFREQ = 100000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             sclk_i,
  input  logic             mosi_i,
  output logic             miso_o,
  output logic [WIDTH-1:0] dout_o,
  output logic             rx_valid_o,
  input  logic [WIDTH-1:0] din_i,
  input  logic             tx_we_i,
  output logic             tx_ready_o,
  output logic             err_o
);

  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

  if (CLKFREQ < SPI_MIN_OVERSAMPLE * SPIFREQ) begin : g_freq_check
    $error("spi_slave_os: CLKFREQ must be at least 4x SPIFREQ");
  end

  logic load_q, load_rise, load_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic [SPI_SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_q;

  spi_sync_edge u_load_sync (
    .clk_i (clk_i), .rst_ni (rst_ni), .d_i (load_i),
    .q_o (load_q), .rise_o (load_rise), .fall_o (load_fall)
  );

  spi_sync_edge u_sclk_sync (
    .clk_i (clk_i), .rst_ni (rst_ni), .d_i (sclk_i),
    .q_o (sclk_q), .rise_o (sclk_rise), .fall_o (sclk_fall)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SPI_SYNC_STAGES-2:0], mosi_i};
    end
  end

  assign mosi_q = mosi_sync_q[SPI_SYNC_STAGES-1];

  spi_os_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_rx_q, sr_rx_d;
  logic [WIDTH-1:0] sr_tx_q, sr_tx_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             tx_ready_q, tx_ready_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rx_valid_q, rx_valid_d;
`ifdef SPI_SLAVE_OS_ERR_EN
  logic             err_q, err_d;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_rx_q    <= '0;
      sr_tx_q    <= '0;
      buf_q      <= '0;
      tx_ready_q <= 1'b1;
      dout_q     <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_rx_q    <= sr_rx_d;
      sr_tx_q    <= sr_tx_d;
      buf_q      <= buf_d;
      tx_ready_q <= tx_ready_d;
      dout_q     <= dout_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_rx_d    = sr_rx_q;
    sr_tx_d    = sr_tx_q;
    buf_d      = buf_q;
    tx_ready_d = tx_ready_q;
    dout_d     = dout_q;
    rx_valid_d = 1'b0;
`ifdef SPI_SLAVE_OS_ERR_EN
    err_d      = 1'b0;
`endif

    if (tx_we_i) begin
      if (tx_ready_q) begin
        buf_d      = din_i;
        tx_ready_d = 1'b0;
      end
`ifdef SPI_SLAVE_OS_ERR_EN
      else begin
        err_d = 1'b1;
      end
`endif
    end

    case (state_q)
      IDLE: begin
        if (load_fall) begin
          state_d = ACTIVE;
          cnt_d   = '0;
          // Frame start sees the buffer as it was before any same-cycle write.
          if (!tx_ready_q) begin
            sr_tx_d    = buf_q;
            tx_ready_d = 1'b1;
          end else begin
            sr_tx_d = '0;
`ifdef SPI_SLAVE_OS_ERR_EN
            err_d   = 1'b1;
`endif
          end
        end
      end
      ACTIVE: begin
        if (sclk_rise) begin
          sr_rx_d = {sr_rx_q[WIDTH-2:0], mosi_q};
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (sclk_fall) begin
          sr_tx_d = {sr_tx_q[WIDTH-2:0], 1'b0};
        end
        if (load_rise) begin
          state_d = END;
        end
      end
      END: begin
        if (cnt_q == CNT_FULL) begin
          dout_d     = sr_rx_q;
          rx_valid_d = 1'b1;
        end
`ifdef SPI_SLAVE_OS_ERR_EN
        else begin
          err_d = 1'b1;
        end
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SPI_SLAVE_OS_ERR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // load_q/sclk_q are only consumed through their edge strobes.
  logic unused_sync;
  assign unused_sync = load_q ^ sclk_q;

  assign miso_o     = (state_q == ACTIVE) & sr_tx_q[WIDTH-1];
  assign dout_o     = dout_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_ready_o = tx_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_os.sv
// ============================================================================
// Module   : tb_spi_slave_os
// Brief    : Self-checking bench for spi_slave_os with a behavioural SPI master.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_slave_os;

  localparam int W = 13;
  localparam int H = 8;  // sclk half period in clk cycles
`ifdef SPI_SLAVE_OS_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b1;
  logic         sclk = 1'b0;
  logic         mosi = 1'b0;
  logic         miso;
  logic [W-1:0] dout;
  logic         rx_valid;
  logic [W-1:0] din = '0;
  logic         tx_we = 1'b0;
  logic         tx_ready;
  logic         err;

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;
  int rx_cnt   = 0;
  int err_base;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mrx, mrx2;

  always #5 clk = ~clk;

  spi_slave_os #(.WIDTH(W), .CLKFREQ(27000000), .SPIFREQ(100000)) u_dut (
    .clk_i (clk), .rst_ni (rst_n), .load_i (load), .sclk_i (sclk),
    .mosi_i (mosi), .miso_o (miso), .dout_o (dout), .rx_valid_o (rx_valid),
    .din_i (din), .tx_we_i (tx_we), .tx_ready_o (tx_ready), .err_o (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && err) err_cnt++;
    if (rst_n && rx_valid) begin
      rx_cnt++;
      if (exp_q.size() == 0) check("rx_spurious", 32'd1, 32'd0);
      else check("rx_dout", 32'(dout), 32'(exp_q.pop_front()));
    end
  end

  task automatic reset_outputs_check(input string tag);
    check({tag, "_dout"},     32'(dout),     32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
    check({tag, "_miso"},     32'(miso),     32'd0);
    check({tag, "_err"},      32'(err),      32'd0);
  endtask

  task automatic tx_write(input logic [W-1:0] v);
    @(negedge clk);
    din   = v;
    tx_we = 1'b1;
    @(negedge clk);
    tx_we = 1'b0;
  endtask

  task automatic spi_frame(input logic [W-1:0] mtx, input int nbits, input int gap,
                           input int rst_bit, output logic [W-1:0] rx);
    logic [W-1:0] txs;
    txs = mtx;
    rx  = '0;
    @(negedge clk);
    load = 1'b0;
    mosi = txs[W-1];
    txs  = txs << 1;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_outputs_check("midrst");
        rst_n = 1'b1;
        @(negedge clk);
      end
      sclk = 1'b1;
      rx   = {rx[W-2:0], miso};
      repeat (H) @(negedge clk);
      sclk = 1'b0;
      mosi = txs[W-1];
      txs  = txs << 1;
      repeat (H) @(negedge clk);
    end
    load = 1'b1;
    mosi = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    reset_outputs_check("rst");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Nominal frame with a preloaded transmit word.
    err_base = err_cnt;
    tx_write(13'h0ced);
    check("t1_tx_ready_full", 32'(tx_ready), 32'd0);
    exp_q.push_back(13'h1dad);
    spi_frame(13'h1dad, W, 20, -1, mrx);
    check("t1_master_rx", 32'(mrx), 32'h0ced);
    check("t1_tx_ready", 32'(tx_ready), 32'd1);
    check("t1_err", 32'(err_cnt - err_base), 32'd0);

    // Underrun: nothing written beforehand.
    err_base = err_cnt;
    exp_q.push_back(13'h1234);
    spi_frame(13'h1234, W, 20, -1, mrx);
    check("t2_master_rx", 32'(mrx), 32'h0000);
    check("t2_err", 32'(err_cnt - err_base), 32'(ERR_EN));

    // Short frame (12 clocks) must be discarded.
    tx_write(13'h0aaa);
    err_base = err_cnt;
    spi_frame(13'h0abc, 12, 20, -1, mrx);
    check("t3_dout_held", 32'(dout), 32'h1234);
    check("t3_master_rx", 32'(mrx), 32'(13'h0aaa >> 1));
    check("t3_err", 32'(err_cnt - err_base), 32'(ERR_EN));

    // Overflow: second write is dropped.
    err_base = err_cnt;
    tx_write(13'h0111);
    tx_write(13'h0222);
    check("t4_tx_ready", 32'(tx_ready), 32'd0);
    check("t4_err_ovf", 32'(err_cnt - err_base), 32'(ERR_EN));
    exp_q.push_back(13'h0f0f);
    spi_frame(13'h0f0f, W, 20, -1, mrx);
    check("t4_master_rx", 32'(mrx), 32'h0111);

    // Reset in the middle of a frame, then a clean (underrun) frame.
    spi_frame(13'h1fff, W, 20, 6, mrx);
    check("t5_dout_after_abort", 32'(dout), 32'd0);
    err_base = err_cnt;
    exp_q.push_back(13'h0555);
    spi_frame(13'h0555, W, 20, -1, mrx);
    check("t5_dout", 32'(dout), 32'h0555);
    check("t5_err", 32'(err_cnt - err_base), 32'(ERR_EN));

    // Back-to-back frames with minimum load-high gap.
    tx_write(13'h1111);
    err_base = err_cnt;
    exp_q.push_back(13'h1dad);
    exp_q.push_back(13'h0ced);
    spi_frame(13'h1dad, W, 2, -1, mrx);
    spi_frame(13'h0ced, W, 20, -1, mrx2);
    check("t6_master_rx1", 32'(mrx), 32'h1111);
    check("t6_master_rx2", 32'(mrx2), 32'h0000);
    check("t6_err", 32'(err_cnt - err_base), 32'(ERR_EN));

    check("rx_pending", 32'(exp_q.size()), 32'd0);
    check("rx_pulses", 32'(rx_cnt), 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
